// File: rtl/chan_mux_scan.sv
// chan_mux_scan: N-channel, W-bit selector with a registered output, a held
// channel-select register, manual load and automatic round-robin scan.
// Optional build macro CHAN_MUX_SCAN_BLANK_EN: forces out to BLANK_VAL in
// every cycle tick is high, hiding the old channel across a select change.

// One channel of the selector: passes its data only when selected, so the
// lane outputs are one-hot and can simply be OR-ed together.
module chan_mux_scan_lane #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  assign dout = (sel == SEL_W'(IDX)) ? din : '0;
endmodule

module chan_mux_scan #(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 4,
  parameter int SEL_W     = 2,
  parameter int PERIOD    = 1000,
  parameter int BLANK_VAL = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic                      sel_load,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      tick
);

  // counter only ever needs to reach PERIOD-1
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(PERIOD - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [WIDTH-1:0] BLANK_W  = WIDTH'(BLANK_VAL);

`ifdef CHAN_MUX_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic [CNT_W-1:0]                cnt, cnt_d;
  logic [SEL_W-1:0]                sel_d;
  logic                            tick_d;
  logic                            load_ok;
  logic                            term;
  logic [WIDTH-1:0]                mux_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  lane_q;

  // per-channel gated data, selected by the held register (never by sel_in)
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    chan_mux_scan_lane #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W),
      .IDX   (k)
    ) u_lane (
      .sel  (cur_sel),
      .din  (in_bus[k*WIDTH +: WIDTH]),
      .dout (lane_q[k])
    );
  end

  // OR-combine the one-hot lane outputs
  always_comb begin
    mux_d = '0;
    for (int k = 0; k < CHANNELS; k++) mux_d = mux_d | lane_q[k];
  end

  // out-of-range loads behave exactly as if no strobe had been given
  assign load_ok = sel_load && (32'(sel_in) < 32'(CHANNELS));
  assign term    = (cnt == CNT_TERM);

  // next select / counter / tick: load beats scan advance beats hold
  always_comb begin
    sel_d  = cur_sel;
    cnt_d  = '0;
    tick_d = 1'b0;
    if (load_ok) begin
      sel_d  = sel_in;
      tick_d = 1'b1;
    end else if (mode) begin
      if (term) begin
        sel_d  = (cur_sel == SEL_LAST) ? '0 : cur_sel + SEL_W'(1);
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt + CNT_W'(1);
      end
    end
  end

  // state and registered output; out samples the channel held this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_sel <= '0;
      cnt     <= '0;
      tick    <= 1'b0;
      out     <= '0;
    end else begin
      cur_sel <= sel_d;
      cnt     <= cnt_d;
      tick    <= tick_d;
      out     <= (BLANK_EN && tick_d) ? BLANK_W : mux_d;
    end
  end

endmodule

// File: tb/tb_chan_mux_scan.sv
// Table-driven bench for chan_mux_scan: a 4-channel PERIOD=3 instance and a
// 3-channel PERIOD=1 instance, expectations queued at drive time.
module tb_chan_mux_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: 4 channels, PERIOD 3
  logic       rst1, mode1, ld1;
  logic [1:0] sin1;
  logic [3:0] o1;
  logic [1:0] s1;
  logic       t1;
  logic [15:0] bus1 = {4'hD, 4'hC, 4'hB, 4'hA};

  // second instance: 3 channels (non power of 2), PERIOD 1
  logic       rst2, mode2, ld2;
  logic [1:0] sin2;
  logic [3:0] o2;
  logic [1:0] s2;
  logic       t2;
  logic [11:0] bus2 = {4'hC, 4'hB, 4'hA};

  chan_mux_scan #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .PERIOD(3), .BLANK_VAL(0)) dut1 (
    .clk(clk), .rst_n(rst1), .mode(mode1), .sel_load(ld1), .sel_in(sin1),
    .in_bus(bus1), .out(o1), .cur_sel(s1), .tick(t1));

  chan_mux_scan #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .PERIOD(1), .BLANK_VAL(0)) dut2 (
    .clk(clk), .rst_n(rst2), .mode(mode2), .sel_load(ld2), .sel_in(sin2),
    .in_bus(bus2), .out(o2), .cur_sel(s2), .tick(t2));

  typedef struct {
    bit         d2;
    bit         rst_n;
    bit         mode;
    bit         ld;
    logic [1:0] sin;
    logic [3:0] eo;   // channel data expected without blanking
    logic [1:0] es;
    bit         et;
  } vec_t;

  typedef struct {
    int         idx;
    bit         d2;
    logic [3:0] eo;
    logic [1:0] es;
    bit         et;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic add(bit d2, bit r, bit m, bit l, logic [1:0] si,
                     logic [3:0] eo, logic [1:0] es, bit et);
    vec_t v;
    v.d2 = d2; v.rst_n = r; v.mode = m; v.ld = l; v.sin = si;
    v.eo = eo; v.es = es; v.et = et;
    vecs.push_back(v);
  endtask

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst1 = 0; mode1 = 0; ld1 = 0; sin1 = 0;
    rst2 = 0; mode2 = 0; ld2 = 0; sin2 = 0;

    //  d2 rst mode ld sin  out    sel  tick
    // reset held with scan requested, then release
    add(0, 0, 1, 0, 0, 4'h0, 2'd0, 0);
    add(0, 0, 1, 0, 0, 4'h0, 2'd0, 0);
    add(0, 1, 0, 0, 0, 4'hA, 2'd0, 0);
    // manual loads, including reload of the same index
    add(0, 1, 0, 1, 2, 4'hA, 2'd2, 1);
    add(0, 1, 0, 0, 0, 4'hC, 2'd2, 0);
    add(0, 1, 0, 1, 3, 4'hC, 2'd3, 1);
    add(0, 1, 0, 0, 0, 4'hD, 2'd3, 0);
    add(0, 1, 0, 1, 3, 4'hD, 2'd3, 1);
    add(0, 1, 0, 0, 0, 4'hD, 2'd3, 0);
    add(0, 1, 0, 1, 0, 4'hD, 2'd0, 1);
    add(0, 1, 0, 0, 0, 4'hA, 2'd0, 0);
    // scan for 15 cycles: 0->1->2->3->0->1 every third edge
    add(0, 1, 1, 0, 0, 4'hA, 2'd0, 0);
    add(0, 1, 1, 0, 0, 4'hA, 2'd0, 0);
    add(0, 1, 1, 0, 0, 4'hA, 2'd1, 1);
    add(0, 1, 1, 0, 0, 4'hB, 2'd1, 0);
    add(0, 1, 1, 0, 0, 4'hB, 2'd1, 0);
    add(0, 1, 1, 0, 0, 4'hB, 2'd2, 1);
    add(0, 1, 1, 0, 0, 4'hC, 2'd2, 0);
    add(0, 1, 1, 0, 0, 4'hC, 2'd2, 0);
    add(0, 1, 1, 0, 0, 4'hC, 2'd3, 1);
    add(0, 1, 1, 0, 0, 4'hD, 2'd3, 0);
    add(0, 1, 1, 0, 0, 4'hD, 2'd3, 0);
    add(0, 1, 1, 0, 0, 4'hD, 2'd0, 1);
    add(0, 1, 1, 0, 0, 4'hA, 2'd0, 0);
    add(0, 1, 1, 0, 0, 4'hA, 2'd0, 0);
    add(0, 1, 1, 0, 0, 4'hA, 2'd1, 1);
    // load of 1 collides with terminal count: load wins, counter restarts
    add(0, 1, 1, 0, 0, 4'hB, 2'd1, 0);
    add(0, 1, 1, 0, 0, 4'hB, 2'd1, 0);
    add(0, 1, 1, 1, 1, 4'hB, 2'd1, 1);
    add(0, 1, 1, 0, 0, 4'hB, 2'd1, 0);
    add(0, 1, 1, 0, 0, 4'hB, 2'd1, 0);
    add(0, 1, 1, 0, 0, 4'hB, 2'd2, 1);
    add(0, 1, 1, 0, 0, 4'hC, 2'd2, 0);
    // drop to manual (counter clears), rise again: advance PERIOD edges later
    add(0, 1, 0, 0, 0, 4'hC, 2'd2, 0);
    add(0, 1, 1, 0, 0, 4'hC, 2'd2, 0);
    add(0, 1, 1, 0, 0, 4'hC, 2'd2, 0);
    add(0, 1, 1, 0, 0, 4'hC, 2'd3, 1);
    // reset mid-scan
    add(0, 0, 1, 0, 0, 4'h0, 2'd0, 0);
    add(0, 1, 1, 0, 0, 4'hA, 2'd0, 0);
    // 3-channel instance: illegal load ignored, PERIOD=1 scan wraps 2->0
    add(1, 0, 0, 0, 0, 4'h0, 2'd0, 0);
    add(1, 1, 0, 1, 2, 4'hA, 2'd2, 1);
    add(1, 1, 0, 0, 0, 4'hC, 2'd2, 0);
    add(1, 1, 0, 1, 3, 4'hC, 2'd2, 0);
    add(1, 1, 0, 0, 0, 4'hC, 2'd2, 0);
    add(1, 1, 1, 0, 0, 4'hC, 2'd0, 1);
    add(1, 1, 1, 0, 0, 4'hA, 2'd1, 1);
    add(1, 1, 1, 0, 0, 4'hB, 2'd2, 1);
    add(1, 1, 1, 0, 0, 4'hC, 2'd0, 1);
    add(1, 1, 0, 0, 0, 4'hA, 2'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(negedge clk);
      if (vecs[i].d2) begin
        rst1 = 1'b0;
        rst2 = vecs[i].rst_n; mode2 = vecs[i].mode;
        ld2  = vecs[i].ld;    sin2  = vecs[i].sin;
      end else begin
        rst2 = 1'b0;
        rst1 = vecs[i].rst_n; mode1 = vecs[i].mode;
        ld1  = vecs[i].ld;    sin1  = vecs[i].sin;
      end
      e.idx = i; e.d2 = vecs[i].d2; e.es = vecs[i].es; e.et = vecs[i].et;
`ifdef CHAN_MUX_SCAN_BLANK_EN
      e.eo = vecs[i].et ? 4'h0 : vecs[i].eo;
`else
      e.eo = vecs[i].eo;
`endif
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.d2) begin
        chk("out",     e.idx, 32'(o2), 32'(e.eo));
        chk("cur_sel", e.idx, 32'(s2), 32'(e.es));
        chk("tick",    e.idx, 32'(t2), 32'(e.et));
      end else begin
        chk("out",     e.idx, 32'(o1), 32'(e.eo));
        chk("cur_sel", e.idx, 32'(s1), 32'(e.es));
        chk("tick",    e.idx, 32'(t1), 32'(e.et));
      end
    end

    chk("sb_empty", vecs.size(), 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
